branch_comparator_seq: RTL

//  Multi-cycle rs1/rs2 comparator for RV64 branches. Produces the EQ/LS/LU flags

---
 rtl/branch_comparator_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/branch_comparator_seq.sv
// branch_comparator_seq
// Multi-cycle RV64 branch operand comparator. Walks the operands CHUNK bits
// per cycle, most significant chunk first, and produces the EQ / LS / LU flags
// consumed by the B-type decoder. A start/busy/valid handshake lets the
// control FSM stall fetch until the flags are ready.
//
// Build option:
//   BRANCH_CMP_EARLY_EXIT_EN - when defined, the compare finishes on the same
//   edge that finds the first differing chunk. Otherwise every compare takes
//   exactly N = XLEN/CHUNK cycles. Flag values are identical in both builds.

module branch_comparator_seq #(
    parameter int XLEN  = 64,
    parameter int CHUNK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            valid,
    output logic            EQ,
    output logic            LS,
    output logic            LU
);

    localparam int N     = XLEN / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

    generate
        if ((XLEN % CHUNK) != 0) begin : g_bad_chunk
            $error("branch_comparator_seq: XLEN must be a multiple of CHUNK");
        end
    endgenerate

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CMP  = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Latched operands (pure datapath, no reset needed)
    logic [XLEN-1:0] a_q, b_q;

    // Compare progress
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             decided_q, decided_d;
    logic             ltu_q, ltu_d;

    // Registered results
    logic valid_q, valid_d;
    logic eq_q, eq_d;
    logic ls_q, ls_d;
    logic lu_q, lu_d;

    // Per-cycle compare terms
    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic             chunk_diff;
    logic             chunk_lt;
    logic             dec_now;
    logic             ltu_now;
    logic             finish;
    logic             accept;
    logic             res_lu;

    // Select the chunk under inspection and fold it into the running decision
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == i[IDX_W-1:0]) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        chunk_diff = (a_chunk != b_chunk);
        chunk_lt   = (a_chunk < b_chunk);
        // A decision made on a higher chunk is never overridden by lower ones
        dec_now    = decided_q | chunk_diff;
        ltu_now    = decided_q ? ltu_q : (chunk_diff & chunk_lt);
`ifdef BRANCH_CMP_EARLY_EXIT_EN
        finish     = (state_q == S_CMP) && ((idx_q == '0) || (chunk_diff && !decided_q));
`else
        finish     = (state_q == S_CMP) && (idx_q == '0);
`endif
        res_lu     = dec_now & ltu_now;
    end

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)  state_d = S_CMP;
            S_CMP:   if (finish) state_d = S_IDLE;
            default:             state_d = S_IDLE;
        endcase
    end

    // FSM outputs: busy flag and the accept strobe for new requests
    always_comb begin
        busy   = (state_q == S_CMP);
        accept = (state_q == S_IDLE) && start;
    end

    // Next values for compare progress and result registers
    always_comb begin
        idx_d     = idx_q;
        decided_d = decided_q;
        ltu_d     = ltu_q;
        valid_d   = 1'b0;
        eq_d      = eq_q;
        ls_d      = ls_q;
        lu_d      = lu_q;
        if (accept) begin
            idx_d     = IDX_TOP;
            decided_d = 1'b0;
            ltu_d     = 1'b0;
        end else if (finish) begin
            idx_d   = '0;
            valid_d = 1'b1;
            eq_d    = ~dec_now;
            lu_d    = res_lu;
            // Opposite signs decide the signed result outright
            ls_d    = (a_q[XLEN-1] != b_q[XLEN-1]) ? a_q[XLEN-1] : res_lu;
        end else if (state_q == S_CMP) begin
            idx_d     = idx_q - 1'b1;
            decided_d = dec_now;
            ltu_d     = ltu_now;
        end
    end

    // Control and result registers; reset aborts any compare and clears flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q     <= '0;
            decided_q <= 1'b0;
            ltu_q     <= 1'b0;
            valid_q   <= 1'b0;
            eq_q      <= 1'b0;
            ls_q      <= 1'b0;
            lu_q      <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            decided_q <= decided_d;
            ltu_q     <= ltu_d;
            valid_q   <= valid_d;
            eq_q      <= eq_d;
            ls_q      <= ls_d;
            lu_q      <= lu_d;
        end
    end

    // Operand capture on the accepting edge; inputs are free to change after
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= rs1;
            b_q <= rs2;
        end
    end

    assign valid = valid_q;
    assign EQ    = eq_q;
    assign LS    = ls_q;
    assign LU    = lu_q;

endmodule
